// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder: one 4-bit carry-skip slice per cycle, LSB nibble first.
// Optional skip statistics output enabled by NIBBLE_SKIP_STATS_EN.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef NIBBLE_SKIP_STATS_EN
    output logic [$clog2(WIDTH/4+1)-1:0] skip_cnt,
`endif
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [4:0]       c;
    logic [3:0]       s_nib;
    logic             skip;
    logic             c_nib;

    always_comb begin
        a_sh  = a_q >> {idx, 2'b00};
        b_sh  = b_q >> {idx, 2'b00};
        a_nib = a_sh[3:0];
        b_nib = b_sh[3:0];
        p     = a_nib ^ b_nib;
        g     = a_nib & b_nib;
        c     = '0;
        c[0]  = carry;
        for (int j = 0; j < 4; j++) begin
            c[j+1] = g[j] | (p[j] & c[j]);
        end
        s_nib = p ^ c[3:0];
        // All-propagate slice forwards the incoming carry directly
        skip  = &p;
        c_nib = skip ? carry : c[4];
    end

`ifdef NIBBLE_SKIP_STATS_EN
    localparam int CW = $clog2(NIB + 1);
    logic [CW-1:0] skip_q;
    assign skip_cnt = skip_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef NIBBLE_SKIP_STATS_EN
            skip_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        idx      <= '0;
                        state    <= ADD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef NIBBLE_SKIP_STATS_EN
                        skip_q   <= '0;
`endif
                    end
                end
                ADD: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (IW'(k) == idx) begin
                            sum[4*k +: 4] <= s_nib;
                        end
                    end
                    carry <= c_nib;
`ifdef NIBBLE_SKIP_STATS_EN
                    skip_q <= skip_q + CW'(skip);
`endif
                    if (idx == LAST) begin
                        cout      <= c_nib;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl (WIDTH=16) against an arithmetic model.
// Skip statistics checked when NIBBLE_SKIP_STATS_EN is defined.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef NIBBLE_SKIP_STATS_EN
    logic [$clog2(NIB+1)-1:0] skip_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
`ifdef NIBBLE_SKIP_STATS_EN
        .skip_cnt(skip_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] model_add(
        input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Number of nibbles in which every bit position propagates
    function automatic int model_skips(
        input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n = 0;
        for (int k = 0; k < NIB; k++) begin
            if (((x >> (4*k)) & 16'hF) ^ ((y >> (4*k)) & 16'hF)) begin
                if ((((x >> (4*k)) ^ (y >> (4*k))) & 16'hF) == 16'hF) n++;
            end
        end
        return n;
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic ci);
        int t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy/vld/busy/cout=%b sum=%h, want 1000 sum=0000",
                     {in_ready, out_valid, busy, cout}, sum);
        end
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(lat);
        n_cmp++;
        if (lat !== NIB) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want %0d", lat, NIB);
        end
        n_cmp++;
        if ({cout, sum} !== 17'h05555) begin
            n_err++;
            $display("FAIL basic_sum: got %b_%h want 0_5555", cout, sum);
        end
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_flags: busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        release_result();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h5555) begin
            n_err++;
            $display("FAIL basic_idle_retain: rdy=%b vld=%b sum=%h want 1 0 5555",
                     in_ready, out_valid, sum);
        end
    endtask

    task automatic test_skip_chain();
        int lat;
        start_op(16'hFFFF, 16'h0000, 1'b1);
        wait_done(lat);
        n_cmp++;
        if ({cout, sum} !== 17'h10000 || lat !== NIB) begin
            n_err++;
            $display("FAIL skip_chain: got %b_%h lat %0d want 1_0000 lat %0d",
                     cout, sum, lat, NIB);
        end
`ifdef NIBBLE_SKIP_STATS_EN
        n_cmp++;
        if (skip_cnt !== 3'd4) begin
            n_err++;
            $display("FAIL skip_cnt_chain: got %0d want 4", skip_cnt);
        end
`endif
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [WIDTH:0] exp;
        exp = model_add(16'hA5A5, 16'h5A5B, 1'b0);
        start_op(16'hA5A5, 16'h5A5B, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cout, sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold%0d: got %b_%h vld=%b rdy=%b want %b_%h 1 0",
                         i, cout, sum, out_valid, in_ready, exp[WIDTH], exp[WIDTH-1:0]);
            end
        end
        release_result();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_ignore_changes();
        int lat;
        logic [WIDTH:0] exp1;
        logic [WIDTH:0] exp2;
        exp1 = model_add(16'h0F0F, 16'h1111, 1'b1);
        exp2 = model_add(16'h7777, 16'h0123, 1'b0);
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h1111;
        cin = 1'b1;
        @(negedge clk);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ignore_ready_add: rdy=%b want 0", in_ready);
            end
            @(negedge clk);
            lat++;
        end
        repeat (2) begin
            a = WIDTH'($urandom);
            @(negedge clk);
        end
        n_cmp++;
        if ({cout, sum} !== exp1 || lat !== NIB) begin
            n_err++;
            $display("FAIL ignore_result: got %b_%h lat %0d want %b_%h lat %0d",
                     cout, sum, lat, exp1[WIDTH], exp1[WIDTH-1:0], NIB);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_no_bypass: rdy=%b busy=%b want 1 0", in_ready, busy);
        end
        a = 16'h7777;
        b = 16'h0123;
        cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_second_accept: busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        wait_done(lat);
        n_cmp++;
        if ({cout, sum} !== exp2 || lat !== NIB) begin
            n_err++;
            $display("FAIL ignore_second_result: got %b_%h lat %0d want %b_%h lat %0d",
                     cout, sum, lat, exp2[WIDTH], exp2[WIDTH-1:0], NIB);
        end
        release_result();
    endtask

    task automatic test_reset_mid_add();
        logic seen = 1'b0;
        start_op(16'h1111, 16'h2222, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== '0) begin
            n_err++;
            $display("FAIL reset_mid_add: rdy/vld/busy/cout=%b sum=%h want 1000 0000",
                     {in_ready, out_valid, busy, cout}, sum);
        end
`ifdef NIBBLE_SKIP_STATS_EN
        n_cmp++;
        if (skip_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_skip_cnt: got %0d want 0", skip_cnt);
        end
`endif
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_random();
        int lat;
        int stall;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic ci;
        logic [WIDTH:0] exp;
        for (int i = 0; i < 1000; i++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            if ((i % 7) == 0) y = ~x;
            ci = 1'($urandom);
            stall = $urandom_range(0, 3);
            exp = model_add(x, y, ci);
            start_op(x, y, ci);
            wait_done(lat);
            n_cmp++;
            if ({cout, sum} !== exp || lat !== NIB) begin
                n_err++;
                $display("FAIL random_%0d: %h+%h+%b got %b_%h lat %0d want %b_%h lat %0d",
                         i, x, y, ci, cout, sum, lat, exp[WIDTH], exp[WIDTH-1:0], NIB);
            end
`ifdef NIBBLE_SKIP_STATS_EN
            n_cmp++;
            if (int'(skip_cnt) !== model_skips(x, y)) begin
                n_err++;
                $display("FAIL random_skip_%0d: got %0d want %0d",
                         i, skip_cnt, model_skips(x, y));
            end
`endif
            repeat (stall) @(negedge clk);
            n_cmp++;
            if ({cout, sum} !== exp || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL random_stall_%0d: got %b_%h vld=%b want %b_%h 1",
                         i, cout, sum, out_valid, exp[WIDTH], exp[WIDTH-1:0]);
            end
            release_result();
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_skip_chain();
        test_backpressure();
        test_ignore_changes();
        test_reset_mid_add();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant NIB = WIDTH/4, the number of 4-bit carry-skip slice steps per operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  controller can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry into nibble 0.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 cout  output  1  carry out of the top nibble.
REQ-014 busy  output  1  high in ADD or DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur when in_valid and in_ready are both 1 at a clock edge; on accept, a, b and cin are latched, the nibble index is cleared to 0, and the state moves to ADD.
REQ-018 Each ADD cycle SHALL process one nibble, LSB first, using one internal 4-bit carry-skip slice.
REQ-019 Slice behaviour: p[i]=a[i]^b[i]; carry out = running carry if all four p are 1, otherwise the ripple carry; sum bits = a^b^carry rippled.
REQ-020 Each ADD cycle SHALL write the slice sum into sum[4k+3:4k] and update the running carry with the slice carry out.
REQ-021 After nibble NIB-1 is processed, cout SHALL take the final carry and the state SHALL move to DONE.
REQ-022 Latency: out_valid SHALL rise exactly NIB cycles after the accept edge (4 cycles for WIDTH=16).
REQ-023 In DONE, sum and cout SHALL hold stable until out_ready=1; on that edge the state returns to IDLE.
REQ-024 There SHALL be no same-cycle DONE-to-ADD bypass; a new accept SHALL occur no earlier than the cycle after the return to IDLE.
REQ-025 in_valid and operand changes during ADD/DONE SHALL be ignored; latched operands SHALL not change mid-operation.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH, with the overflow bit reported only on cout.
REQ-027 sum and cout SHALL retain the last result in IDLE until the next operation overwrites them nibble by nibble.

Reset
REQ-028 rst=1 at a clock edge SHALL force the state to IDLE and clear sum, cout, the nibble index, the running carry and the latched operands, regardless of current state.
REQ-029 After reset, in_ready=1, out_valid=0 and busy=0; reset during ADD SHALL abort the operation with no out_valid.

Configuration
REQ-030 Macro NIBBLE_SKIP_STATS_EN, when defined, SHALL add output skip_cnt (width clog2(NIB+1)).
REQ-031 skip_cnt SHALL count the nibbles of the current operation whose carry took the skip path; it clears on accept and on reset, and is valid in DONE.
REQ-032 Without NIBBLE_SKIP_STATS_EN, the port and counter SHALL be absent, with identical remaining behaviour.

Verification
REQ-033 Reset: assert rst for 2 cycles mid-ADD -> out_valid=0, in_ready=1, sum=0, cout=0 on the following cycle.
REQ-034 WIDTH=16: a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 cycles after accept, sum=0x5555, cout=0.
REQ-035 Full skip chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; with the macro, skip_cnt=4.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in DONE -> sum/cout stable, in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-037 in_valid asserted throughout with a changing operand during ADD -> result reflects only the latched operand; second accept occurs only after the return to IDLE.
REQ-038 Random: 1000 operand pairs with random cin and out_ready stalls -> {cout,sum} == a+b+cin for every transaction.
